// File: rtl/hazard_sequencer.sv
// hazard_sequencer: ID-side hazard detection and pipeline sequencing.
// Keeps a two-slot shadow scoreboard of the EXE and MEM destinations and
// decides each cycle between freeze, stall (bubble), branch flush and issue.
module hazard_sequencer #(
  parameter int ADDR_W     = 4,
  parameter int BR_PENALTY = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              forward_en,
  input  logic              mem_ready,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic              is_imm,
  input  logic              st_or_bne,
  input  logic              id_is_br,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic              br_taken,
  output logic              hazard_detected,
  output logic              pc_freeze,
  output logic              ifid_freeze,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_freeze,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    FLUSH = 2'b01
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dest;
    logic              wb;
    logic              mr;
  } slot_t;

  state_t             state_reg, state_next;
  slot_t              exe_reg, exe_next;
  slot_t              mem_reg, mem_next;
  logic [2:0]         fcnt_reg, fcnt_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  logic               use_src2;
  logic               exe_m1, exe_m2, mem_m1, mem_m2;
  logic               hz1, hz2, hz;
  logic               flush_c;

  // Source matching against the scoreboard; register 0 is not special.
  always_comb begin
    use_src2 = !is_imm || st_or_bne;
    exe_m1   = exe_reg.valid && exe_reg.wb && (exe_reg.dest == src1);
    exe_m2   = exe_reg.valid && exe_reg.wb && (exe_reg.dest == src2);
    mem_m1   = mem_reg.valid && mem_reg.wb && (mem_reg.dest == src1);
    mem_m2   = mem_reg.valid && mem_reg.wb && (mem_reg.dest == src2);
    // With forwarding only load-use and branches (resolved in ID on raw
    // register values) still need to wait; without it any match waits.
    if (forward_en) begin
      hz1 = (exe_reg.mr && exe_m1) || (id_is_br && (exe_m1 || mem_m1));
      hz2 = (exe_reg.mr && exe_m2) || (id_is_br && (exe_m2 || mem_m2));
    end else begin
      hz1 = exe_m1 || mem_m1;
      hz2 = exe_m2 || mem_m2;
    end
    hz = !rst && id_valid && (state_reg == RUN) && (hz1 || (use_src2 && hz2));
  end

  // Next-state and control outputs; priority is freeze, hazard, flush, issue.
  always_comb begin
    state_next  = state_reg;
    exe_next    = exe_reg;
    mem_next    = mem_reg;
    fcnt_next   = fcnt_reg;
    cnt_next    = cnt_reg;
    pc_freeze   = 1'b0;
    ifid_freeze = 1'b0;
    pipe_freeze = 1'b0;
    idex_bubble = 1'b0;
    flush_c     = 1'b0;
    if (!mem_ready) begin
      pipe_freeze = 1'b1;
      pc_freeze   = 1'b1;
      ifid_freeze = 1'b1;
    end else if (hz) begin
      pc_freeze   = 1'b1;
      ifid_freeze = 1'b1;
      idex_bubble = 1'b1;
      exe_next    = '0;
      mem_next    = exe_reg;
      cnt_next    = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;
    end else if (state_reg == FLUSH) begin
      // ID content is a wrong-path instruction: drop it.
      flush_c   = 1'b1;
      exe_next  = '0;
      mem_next  = exe_reg;
      fcnt_next = fcnt_reg - 3'd1;
      if (fcnt_reg == 3'd1) state_next = RUN;
    end else begin
      exe_next = '{valid: id_valid, dest: id_dest, wb: id_wb_en, mr: id_mem_r_en};
      mem_next = exe_reg;
      if (br_taken) begin
        flush_c = 1'b1;
        if (BR_PENALTY > 1) begin
          state_next = FLUSH;
          fcnt_next  = 3'(BR_PENALTY - 1);
        end
      end
    end
  end

  // Output drive; reset silences flush even if br_taken is high.
  always_comb begin
    hazard_detected = hz;
    ifid_flush      = flush_c && !rst;
    stall_cnt       = cnt_reg;
    state           = state_reg;
  end

  // Registered scoreboard, sequencing state and stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
      exe_reg   <= '0;
      mem_reg   <= '0;
      fcnt_reg  <= 3'd0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      exe_reg   <= exe_next;
      mem_reg   <= mem_next;
      fcnt_reg  <= fcnt_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_hazard_sequencer;

  logic       clk = 1'b0;
  logic       rst, forward_en, mem_ready, id_valid;
  logic [3:0] src1, src2, id_dest;
  logic       is_imm, st_or_bne, id_is_br, id_wb_en, id_mem_r_en, br_taken;

  logic        hd_a, pcf_a, iff_a, fl_a, bub_a, pf_a;
  logic [15:0] cnt_a;
  logic [1:0]  st_a;
  logic        hd_b, pcf_b, iff_b, fl_b, bub_b, pf_b;
  logic [3:0]  cnt_b;
  logic [1:0]  st_b;

  typedef struct packed {
    logic        hd;
    logic        frz;
    logic        ifz;
    logic        fl;
    logic        bub;
    logic        pf;
    logic [15:0] cnt;
    logic [1:0]  st;
  } obs_t;

  obs_t  exp_q[$];
  bit    inst_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  hazard_sequencer dut_a (
    .clk(clk), .rst(rst), .forward_en(forward_en), .mem_ready(mem_ready),
    .id_valid(id_valid), .src1(src1), .src2(src2), .is_imm(is_imm),
    .st_or_bne(st_or_bne), .id_is_br(id_is_br), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .br_taken(br_taken),
    .hazard_detected(hd_a), .pc_freeze(pcf_a), .ifid_freeze(iff_a),
    .ifid_flush(fl_a), .idex_bubble(bub_a), .pipe_freeze(pf_a),
    .stall_cnt(cnt_a), .state(st_a)
  );

  hazard_sequencer #(.ADDR_W(4), .BR_PENALTY(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .forward_en(forward_en), .mem_ready(mem_ready),
    .id_valid(id_valid), .src1(src1), .src2(src2), .is_imm(is_imm),
    .st_or_bne(st_or_bne), .id_is_br(id_is_br), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .br_taken(br_taken),
    .hazard_detected(hd_b), .pc_freeze(pcf_b), .ifid_freeze(iff_b),
    .ifid_flush(fl_b), .idex_bubble(bub_b), .pipe_freeze(pf_b),
    .stall_cnt(cnt_b), .state(st_b)
  );

  task automatic instr(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic imm, input logic stb, input logic br,
                       input logic [3:0] d, input logic wb, input logic mr,
                       input logic bt);
    id_valid = v; src1 = s1; src2 = s2; is_imm = imm; st_or_bne = stb;
    id_is_br = br; id_dest = d; id_wb_en = wb; id_mem_r_en = mr; br_taken = bt;
  endtask

  task automatic idle();
    instr(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input bit inst, input string n, input logic hd, input logic frz,
                      input logic fl, input logic bub, input logic pf,
                      input logic [15:0] c, input logic [1:0] st);
    obs_t e;
    e = '{hd: hd, frz: frz, ifz: frz, fl: fl, bub: bub, pf: pf, cnt: c, st: st};
    exp_q.push_back(e);
    inst_q.push_back(inst);
    name_q.push_back(n);
  endtask

  task automatic ea(input string n, input logic hd, input logic frz, input logic fl,
                    input logic bub, input logic pf, input logic [15:0] c, input logic [1:0] st);
    push(1'b0, n, hd, frz, fl, bub, pf, c, st);
  endtask

  task automatic eb(input string n, input logic hd, input logic frz, input logic fl,
                    input logic bub, input logic pf, input logic [15:0] c, input logic [1:0] st);
    push(1'b1, n, hd, frz, fl, bub, pf, c, st);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    idle();
    ea("reset_a", 0, 0, 0, 0, 0, 16'd0, 2'd0);
    eb("reset_b", 0, 0, 0, 0, 0, 16'd0, 2'd0);
    tick();
    rst = 1'b0;
  endtask

  // Monitor: compare every pending expectation against the live outputs.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        obs_t  e, a;
        bit    inst;
        string n;
        e    = exp_q.pop_front();
        inst = inst_q.pop_front();
        n    = name_q.pop_front();
        if (!inst)
          a = '{hd: hd_a, frz: pcf_a, ifz: iff_a, fl: fl_a, bub: bub_a, pf: pf_a, cnt: cnt_a, st: st_a};
        else
          a = '{hd: hd_b, frz: pcf_b, ifz: iff_b, fl: fl_b, bub: bub_b, pf: pf_b,
                cnt: {12'd0, cnt_b}, st: st_b};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s[%s]: got hd=%b pcf=%b iff=%b fl=%b bub=%b pf=%b cnt=%0d st=%0d, expected hd=%b pcf=%b iff=%b fl=%b bub=%b pf=%b cnt=%0d st=%0d",
                   n, inst ? "b" : "a", a.hd, a.frz, a.ifz, a.fl, a.bub, a.pf, a.cnt, a.st,
                   e.hd, e.frz, e.ifz, e.fl, e.bub, e.pf, e.cnt, e.st);
        end else begin
          $display("ok   %s[%s] hd=%b fl=%b bub=%b pf=%b cnt=%0d st=%0d",
                   n, inst ? "b" : "a", a.hd, a.fl, a.bub, a.pf, a.cnt, a.st);
        end
      end
    end
  end

  // Stimulus: directed scenarios with hand-derived expectations.
  initial begin
    rst = 1'b1; mem_ready = 1'b0; forward_en = 1'b1;
    idle();
    tick();
    // reset held while memory busy: only the freeze lines are high
    ea("rst_frz", 0, 1, 0, 0, 1, 16'd0, 2'd0);
    tick();

    // load-use with forwarding: one stall
    do_reset(); forward_en = 1'b1;
    instr(1, 4'd0, 4'd0, 1, 0, 0, 4'd3, 1, 1, 0); ea("lu_issue", 0, 0, 0, 0, 0, 16'd0, 2'd0); tick();
    instr(1, 4'd3, 4'd1, 0, 0, 0, 4'd4, 1, 0, 0); ea("lu_stall", 1, 1, 0, 1, 0, 16'd0, 2'd0); tick();
    ea("lu_go", 0, 0, 0, 0, 0, 16'd1, 2'd0); tick();
    idle(); ea("lu_done", 0, 0, 0, 0, 0, 16'd1, 2'd0); tick(); tick();

    // no forwarding: two stalls on src2; immediate form hides src2
    do_reset(); forward_en = 1'b0;
    instr(1, 4'd0, 4'd0, 1, 0, 0, 4'd5, 1, 0, 0); ea("nf_issue", 0, 0, 0, 0, 0, 16'd0, 2'd0); tick();
    instr(1, 4'd9, 4'd5, 0, 0, 0, 4'd6, 1, 0, 0); ea("nf_stall1", 1, 1, 0, 1, 0, 16'd0, 2'd0); tick();
    ea("nf_stall2", 1, 1, 0, 1, 0, 16'd1, 2'd0); tick();
    ea("nf_go", 0, 0, 0, 0, 0, 16'd2, 2'd0); tick();
    idle(); tick(); tick();
    instr(1, 4'd0, 4'd0, 1, 0, 0, 4'd5, 1, 0, 0); ea("imm_issue", 0, 0, 0, 0, 0, 16'd2, 2'd0); tick();
    instr(1, 4'd9, 4'd5, 1, 0, 0, 4'd6, 1, 0, 0); ea("imm_nostall", 0, 0, 0, 0, 0, 16'd2, 2'd0); tick();
    instr(1, 4'd9, 4'd5, 1, 1, 0, 4'd7, 1, 0, 0); ea("stb_stall", 1, 1, 0, 1, 0, 16'd2, 2'd0); tick();
    ea("stb_go", 0, 0, 0, 0, 0, 16'd3, 2'd0); tick();
    idle(); tick(); tick();

    // branch on preceding ALU result: two stalls, then taken flush
    do_reset(); forward_en = 1'b1;
    instr(1, 4'd0, 4'd0, 1, 0, 0, 4'd2, 1, 0, 0);
    ea("br_issue", 0, 0, 0, 0, 0, 16'd0, 2'd0); eb("br_issue", 0, 0, 0, 0, 0, 16'd0, 2'd0); tick();
    instr(1, 4'd2, 4'd0, 0, 1, 1, 4'd0, 0, 0, 0);
    ea("br_stall1", 1, 1, 0, 1, 0, 16'd0, 2'd0); eb("br_stall1", 1, 1, 0, 1, 0, 16'd0, 2'd0); tick();
    ea("br_stall2", 1, 1, 0, 1, 0, 16'd1, 2'd0); eb("br_stall2", 1, 1, 0, 1, 0, 16'd1, 2'd0); tick();
    instr(1, 4'd2, 4'd0, 0, 1, 1, 4'd0, 0, 0, 1);
    ea("br_flush", 0, 0, 1, 0, 0, 16'd2, 2'd0); eb("br_flush", 0, 0, 1, 0, 0, 16'd2, 2'd0); tick();
    idle();
    ea("br_after", 0, 0, 0, 0, 0, 16'd2, 2'd0); eb("brf_1", 0, 0, 1, 0, 0, 16'd2, 2'd1); tick();
    idle(); br_taken = 1'b1;
    ea("br_again", 0, 0, 1, 0, 0, 16'd2, 2'd0); eb("brf_2", 0, 0, 1, 0, 0, 16'd2, 2'd1); tick();
    idle(); eb("brf_end", 0, 0, 0, 0, 0, 16'd2, 2'd0); tick();

    // hazard and br_taken together: stall wins, flush follows
    do_reset(); forward_en = 1'b1;
    instr(1, 4'd0, 4'd0, 1, 0, 0, 4'd2, 1, 0, 0); ea("sim_issue", 0, 0, 0, 0, 0, 16'd0, 2'd0); tick();
    instr(1, 4'd2, 4'd0, 0, 1, 1, 4'd0, 0, 0, 1);
    ea("sim_stall1", 1, 1, 0, 1, 0, 16'd0, 2'd0); eb("sim_stall1", 1, 1, 0, 1, 0, 16'd0, 2'd0); tick();
    ea("sim_stall2", 1, 1, 0, 1, 0, 16'd1, 2'd0); tick();
    ea("sim_flush", 0, 0, 1, 0, 0, 16'd2, 2'd0); eb("sim_flush", 0, 0, 1, 0, 0, 16'd2, 2'd0); tick();
    idle(); ea("sim_after", 0, 0, 0, 0, 0, 16'd2, 2'd0); eb("sim_fl1", 0, 0, 1, 0, 0, 16'd2, 2'd1); tick();
    tick(); tick();

    // memory freeze in the middle of a two-cycle stall
    do_reset(); forward_en = 1'b0;
    instr(1, 4'd0, 4'd0, 1, 0, 0, 4'd5, 1, 0, 0); ea("fz_issue", 0, 0, 0, 0, 0, 16'd0, 2'd0); tick();
    instr(1, 4'd5, 4'd0, 1, 0, 0, 4'd6, 1, 0, 0); ea("fz_stall1", 1, 1, 0, 1, 0, 16'd0, 2'd0); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ea("fz_hold", 1, 1, 0, 0, 1, 16'd1, 2'd0); tick();
    end
    mem_ready = 1'b1;
    ea("fz_stall2", 1, 1, 0, 1, 0, 16'd1, 2'd0); tick();
    ea("fz_go", 0, 0, 0, 0, 0, 16'd2, 2'd0); tick();
    idle(); tick(); tick();

    // reset in the middle of FLUSH, with br_taken high while held
    do_reset(); forward_en = 1'b1;
    instr(1, 4'd0, 4'd0, 1, 0, 0, 4'd0, 0, 0, 1); eb("rf_br", 0, 0, 1, 0, 0, 16'd0, 2'd0); tick();
    idle(); eb("rf_fl", 0, 0, 1, 0, 0, 16'd0, 2'd1); tick();
    rst = 1'b1; idle(); br_taken = 1'b1;
    ea("rf_rst", 0, 0, 0, 0, 0, 16'd0, 2'd0); eb("rf_rst", 0, 0, 0, 0, 0, 16'd0, 2'd0); tick();
    rst = 1'b0; idle();
    ea("rf_rel", 0, 0, 0, 0, 0, 16'd0, 2'd0); eb("rf_rel", 0, 0, 0, 0, 0, 16'd0, 2'd0); tick();

    // reset in the middle of a stall: no stall resumes after release
    forward_en = 1'b0;
    instr(1, 4'd0, 4'd0, 1, 0, 0, 4'd5, 1, 0, 0); tick();
    instr(1, 4'd5, 4'd0, 1, 0, 0, 4'd6, 1, 0, 0); ea("rs_stall", 1, 1, 0, 1, 0, 16'd0, 2'd0); tick();
    rst = 1'b1; ea("rs_rst", 0, 0, 0, 0, 0, 16'd0, 2'd0); tick();
    rst = 1'b0; ea("rs_rel", 0, 0, 0, 0, 0, 16'd0, 2'd0); tick();
    idle(); tick(); tick();

    // saturation: 20 stall cycles, the 4-bit counter must hold at 15
    do_reset(); forward_en = 1'b0;
    instr(1, 4'd5, 4'd0, 1, 0, 0, 4'd5, 1, 0, 0);
    for (int i = 0; i < 30; i++) tick();
    idle();
    ea("sat_a", 0, 0, 0, 0, 0, 16'd20, 2'd0); eb("sat_b", 0, 0, 0, 0, 0, 16'd15, 2'd0); tick();

    tick();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
